// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg -- shared types and constants for the RAM arbiter and its helpers.
// Revision: 1.0
`default_nettype none

package ram_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;
  localparam logic [BE_W-1:0] BE_FULL = {BE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    MERGE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/ram_byte_merge.sv
// ram_byte_merge -- per-lane select between an old word and a new word by byte enable.
// Revision: 1.0
`default_nettype none

module ram_byte_merge
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_new,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_merged
);

  for (genvar k = 0; k < DATA_W / 8; k++) begin : g_lane
    assign o_merged[8*k +: 8] = i_be[k] ? i_new[8*k +: 8] : i_old[8*k +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter -- arbitrates fetch and load/store onto a single-port word RAM,
// with read-modify-write for partial stores. Revision: 1.0
`default_nettype none

module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(MAX_DATA_BURST);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_be_full;
  logic              w_be_none;
  logic [DATA_W-1:0] w_merged;

  ram_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .i_old    (ram_rdata),
    .i_new    (d_wdata),
    .i_be     (d_be),
    .o_merged (w_merged)
  );

  always_comb begin
    w_be_full   = &d_be;
    w_be_none   = ~|d_be;
    // Grants are qualified by rst_n so the RAM port stays quiet while reset is held.
    w_grant_i   = rst_n && i_req && (!d_req || (burst_cnt_q == C_BURST_MAX));
    w_grant_d   = rst_n && d_req && !w_grant_i;
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (!i_req) burst_cnt_d = '0;
        if (w_grant_i) begin
          ram_addr    = i_addr;
          owner_d     = GNT_I;
          burst_cnt_d = '0;
          state_d     = ACK;
        end else if (w_grant_d) begin
          ram_addr = d_addr;
          owner_d  = GNT_D;
          if (i_req && (burst_cnt_q != C_BURST_MAX)) burst_cnt_d = burst_cnt_q + 1'b1;
          if (d_we && !w_be_full && !w_be_none) begin
            state_d = MERGE;
          end else begin
            state_d = ACK;
            if (d_we && w_be_full) begin
              ram_we    = 1'b1;
              ram_wdata = d_wdata;
            end
          end
        end
      end
      MERGE: begin
        // ram_rdata holds the word read in the grant cycle.
        ram_we    = 1'b1;
        ram_addr  = d_addr;
        ram_wdata = w_merged;
        state_d   = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= GNT_I;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign i_ack   = (state_q == ACK) && (owner_q == GNT_I);
  assign d_ack   = (state_q == ACK) && (owner_q == GNT_D);
  assign i_rdata = i_ack ? ram_rdata : '0;
  assign d_rdata = d_ack ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter -- directed self-checking bench for ram_arbiter with a registered-read RAM model.
// Revision: 1.0
`default_nettype none

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
    else        ram_rdata <= mem[ram_addr[7:2]];
  end

  ram_arbiter #(
    .ADDR_W         (16),
    .DATA_W         (32),
    .MAX_DATA_BURST (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive_d(input logic we, input logic [3:0] be, input logic [15:0] addr,
                         input logic [31:0] wd);
    @(posedge clk);
    #1;
    d_req   = 1'b1;
    d_we    = we;
    d_be    = be;
    d_addr  = addr;
    d_wdata = wd;
  endtask

  task automatic store_full(input string tag, input logic [15:0] addr, input logic [31:0] wd);
    drive_d(1'b1, 4'hF, addr, wd);
    @(negedge clk);
    check({tag, "_we_n"}, {31'd0, ram_we}, 32'd1);
    check({tag, "_addr_n"}, {16'd0, ram_addr}, {16'd0, addr});
    check({tag, "_wdata_n"}, ram_wdata, wd);
    @(negedge clk);
    check({tag, "_ack_n1"}, {31'd0, d_ack}, 32'd1);
    check({tag, "_we_n1"}, {31'd0, ram_we}, 32'd0);
    d_req = 1'b0;
  endtask

  task automatic load(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    drive_d(1'b0, 4'h0, addr, 32'h0);
    @(negedge clk);
    check({tag, "_we_n"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_addr_n"}, {16'd0, ram_addr}, {16'd0, addr});
    @(negedge clk);
    check({tag, "_ack_n1"}, {31'd0, d_ack}, 32'd1);
    check({tag, "_rdata"}, d_rdata, exp);
    d_req = 1'b0;
  endtask

  initial begin
    logic       got;
    logic [1:0] exp_own;

    rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_i_ack", {31'd0, i_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    rst_n = 1'b1;

    // Preload the word the fetch reads.
    store_full("pre10", 16'h0010, 32'hDEADBEEF);

    @(posedge clk);
    #1;
    i_req  = 1'b1;
    i_addr = 16'h0010;
    @(negedge clk);
    check("fetch_we_n", {31'd0, ram_we}, 32'd0);
    check("fetch_addr_n", {16'd0, ram_addr}, 32'h0010);
    @(negedge clk);
    check("fetch_ack", {31'd0, i_ack}, 32'd1);
    check("fetch_no_d_ack", {31'd0, d_ack}, 32'd0);
    check("fetch_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;

    store_full("full20", 16'h0020, 32'h12345678);
    load("ld20a", 16'h0020, 32'h12345678);

    store_full("pre20", 16'h0020, 32'hAABBCCDD);
    drive_d(1'b1, 4'b0010, 16'h0020, 32'h00001100);
    @(negedge clk);
    check("part_we_n", {31'd0, ram_we}, 32'd0);
    check("part_addr_n", {16'd0, ram_addr}, 32'h0020);
    @(negedge clk);
    check("part_we_n1", {31'd0, ram_we}, 32'd1);
    check("part_wdata_n1", ram_wdata, 32'hAABB11DD);
    check("part_ack_n1", {31'd0, d_ack}, 32'd0);
    @(negedge clk);
    check("part_ack_n2", {31'd0, d_ack}, 32'd1);
    check("part_we_n2", {31'd0, ram_we}, 32'd0);
    d_req = 1'b0;
    load("ld20b", 16'h0020, 32'hAABB11DD);

    drive_d(1'b1, 4'b0000, 16'h0020, 32'hFFFFFFFF);
    @(negedge clk);
    check("noop_we_n", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    check("noop_ack", {31'd0, d_ack}, 32'd1);
    check("noop_we_n1", {31'd0, ram_we}, 32'd0);
    d_req = 1'b0;
    load("ld20c", 16'h0020, 32'hAABB11DD);

    // Reset lands while a partial store sits in MERGE.
    drive_d(1'b1, 4'b0001, 16'h0020, 32'h000000EE);
    @(negedge clk);
    check("abort_we_n", {31'd0, ram_we}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ram_we", {31'd0, ram_we}, 32'd0);
    check("abort_d_ack", {31'd0, d_ack}, 32'd0);
    check("abort_i_ack", {31'd0, i_ack}, 32'd0);
    check("abort_ram_addr", {16'd0, ram_addr}, 32'd0);
    check("abort_ram_wdata", ram_wdata, 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("post_rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("post_rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    load("ld20d", 16'h0020, 32'hAABB11DD);

    // Both requesters held: expect D, D, I repeating.
    @(posedge clk);
    #1;
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 16'h0020; d_wdata = '0;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (i_ack || d_ack) got = 1'b1;
      end
      check($sformatf("fair_seen%0d", g), {31'd0, got}, 32'd1);
      exp_own = (g % 3 == 2) ? 2'b10 : 2'b01;
      check($sformatf("fair_owner%0d", g), {30'd0, i_ack, d_ack}, {30'd0, exp_own});
      if (exp_own == 2'b10) check($sformatf("fair_irdata%0d", g), i_rdata, 32'hDEADBEEF);
      else                  check($sformatf("fair_drdata%0d", g), d_rdata, 32'hAABB11DD);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
